// File: rtl/io_bus_arbiter.sv
// Two-master arbiter and access sequencer for the shared peripheral I/O bus.
// Optional round-robin arbitration is built when IO_ARB_RR_EN is defined (fixed m0 priority otherwise).
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif

module io_bus_arbiter #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_ctrl,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_ctrl,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              bus_en,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_ctrl,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_oe,
   input  logic [DATA_W-1:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              gnt;
   logic              win;
   logic              load;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_ctrl;
   logic [DATA_W-1:0] sel_wdata;
   logic              nxt_ctrl;

`ifdef IO_ARB_RR_EN
   logic last_gnt;

   // On contention the master not granted last wins; a lone requester always wins.
   always_comb win = (m0_req && m1_req) ? ~last_gnt : m1_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       last_gnt <= 1'b1;
      else if (load) last_gnt <= win;
   end
`else
   always_comb win = ~m0_req;
`endif

   always_comb begin
      sel_addr  = win ? m1_addr  : m0_addr;
      sel_ctrl  = win ? m1_ctrl  : m0_ctrl;
      sel_wdata = win ? m1_wdata : m0_wdata;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            if (m0_req || m1_req) begin
               load      = 1'b1;
               cnt_nxt   = 4'(ACCESS_CYCLES - 1);
               state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt == 4'd0) state_nxt = S_ACK;
            else             cnt_nxt   = cnt - 4'd1;
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ctrl of the transaction that will occupy the bus next cycle
   always_comb nxt_ctrl = load ? sel_ctrl : bus_ctrl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         gnt       <= 1'b0;
         bus_en    <= 1'b0;
         bus_oe    <= 1'b0;
         bus_ctrl  <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         bus_en <= (state_nxt == S_ACCESS);
         bus_oe <= (state_nxt == S_ACCESS) && (nxt_ctrl == `IO_CTRL_WRITE);
         m0_ack <= (state_nxt == S_ACK) && !gnt;
         m1_ack <= (state_nxt == S_ACK) &&  gnt;
         if (load) begin
            gnt       <= win;
            bus_addr  <= sel_addr;
            bus_ctrl  <= sel_ctrl;
            bus_wdata <= sel_wdata;
         end
         // Read data is taken on the final access edge, just before ACK.
         if (state == S_ACCESS && cnt == 4'd0 && bus_ctrl == `IO_CTRL_READ) begin
            if (gnt) m1_rdata <= bus_rdata;
            else     m0_rdata <= bus_rdata;
         end
      end
   end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: directed transactions, monitor checks bus and acks.
module tb_io_bus_arbiter;
   localparam int   AW = 16;
   localparam int   DW = 16;
   localparam int   AC = 2;
   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m1_req, m0_ctrl, m1_ctrl, m0_ack, m1_ack;
   logic [AW-1:0] m0_addr, m1_addr, bus_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, bus_wdata, bus_rdata;
   logic          bus_en, bus_ctrl, bus_oe;

   always #5 clk = ~clk;

   io_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_ctrl(m0_ctrl), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_ctrl(m1_ctrl), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .bus_en(bus_en), .bus_addr(bus_addr), .bus_ctrl(bus_ctrl), .bus_wdata(bus_wdata),
      .bus_oe(bus_oe), .bus_rdata(bus_rdata)
   );

   // Device model: one fixed register, everything else returns a pattern of the address.
   function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
      return (a == 16'h0020) ? 16'h1234 : (a ^ 16'hA5A5);
   endfunction
   assign bus_rdata = dev_rd(bus_addr);

   typedef struct {
      logic          m;
      logic [AW-1:0] addr;
      logic          ctrl;
      logic [DW-1:0] wdata;
   } txn_t;

   txn_t          sbq[$];
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_rd0 = '0;
   logic [DW-1:0] exp_rd1 = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void exp_push(input logic m, input logic [AW-1:0] a, input logic c,
                                    input logic [DW-1:0] w);
      txn_t t;
      t.m = m; t.addr = a; t.ctrl = c; t.wdata = w;
      sbq.push_back(t);
   endfunction

   // Monitor
   initial begin
      int   en_cnt;
      txn_t t;
      en_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            en_cnt = 0;
         end else begin
            if (bus_en) begin
               if (sbq.size() == 0) chk("unexpected_bus_en", 32'(bus_en), 0);
               else begin
                  chk("bus_addr", 32'(bus_addr), 32'(sbq[0].addr));
                  chk("bus_ctrl", 32'(bus_ctrl), 32'(sbq[0].ctrl));
                  chk("bus_oe", 32'(bus_oe), 32'(sbq[0].ctrl == WR));
                  if (sbq[0].ctrl == WR) chk("bus_wdata", 32'(bus_wdata), 32'(sbq[0].wdata));
               end
               en_cnt++;
            end else begin
               chk("bus_oe_released", 32'(bus_oe), 0);
            end
            if (m0_ack || m1_ack) begin
               chk("ack_onehot", 32'(m0_ack & m1_ack), 0);
               if (sbq.size() == 0) chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 0);
               else begin
                  t = sbq.pop_front();
                  chk("ack_master", 32'(m1_ack), 32'(t.m));
                  chk("access_len", 32'(en_cnt), 32'(AC));
                  if (t.ctrl == RD) begin
                     if (t.m) exp_rd1 = dev_rd(t.addr);
                     else     exp_rd0 = dev_rd(t.addr);
                  end
                  chk("m0_rdata", 32'(m0_rdata), 32'(exp_rd0));
                  chk("m1_rdata", 32'(m1_rdata), 32'(exp_rd1));
               end
               en_cnt = 0;
            end
         end
      end
   end

   task automatic drive(input int m, input logic req, input logic [AW-1:0] a, input logic c,
                        input logic [DW-1:0] w);
      if (m == 0) begin m0_req = req; m0_addr = a; m0_ctrl = c; m0_wdata = w; end
      else        begin m1_req = req; m1_addr = a; m1_ctrl = c; m1_wdata = w; end
   endtask

   task automatic wait_ack(input int m, output int cyc);
      logic seen;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         seen = (m == 0) ? m0_ack : m1_ack;
      end
      if (!seen) chk("ack_timeout", 32'(seen), 1);
   endtask

   // Keeps req high across n back-to-back transactions, then drops it on the last ack.
   task automatic run_master(input int m, input int n, input logic [AW-1:0] a0, input logic c,
                             input logic [DW-1:0] w0, output int first_cyc);
      int cyc;
      first_cyc = 0;
      for (int i = 0; i < n; i++) begin
         drive(m, 1'b1, a0 + 16'(i), c, w0 + 16'(i));
         wait_ack(m, cyc);
         if (i == 0) first_cyc = cyc;
      end
      drive(m, 1'b0, a0, c, w0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c, c0, c1;
      rst = 1'b1;
      drive(0, 1'b0, '0, RD, '0);
      drive(1, 1'b0, '0, RD, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bus_en", 32'(bus_en), 0);
      chk("rst_bus_oe", 32'(bus_oe), 0);
      chk("rst_bus_ctrl", 32'(bus_ctrl), 0);
      chk("rst_acks", {30'd0, m1_ack, m0_ack}, 0);
      chk("rst_bus_addr", 32'(bus_addr), 0);
      chk("rst_bus_wdata", 32'(bus_wdata), 0);
      chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single write from m0
      exp_push(1'b0, 16'h0010, WR, 16'hBEEF);
      run_master(0, 1, 16'h0010, WR, 16'hBEEF, c);
      chk("wr_latency", 32'(c), 32'(AC + 1));
      @(posedge clk); #1;

      // Single read from m1
      exp_push(1'b1, 16'h0020, RD, '0);
      run_master(1, 1, 16'h0020, RD, '0, c);
      chk("rd_latency", 32'(c), 32'(AC + 1));
      @(posedge clk); #1;

      // Master inputs change during ACCESS; the bus must keep the latched values
      exp_push(1'b0, 16'h0040, WR, 16'hCAFE);
      drive(0, 1'b1, 16'h0040, WR, 16'hCAFE);
      @(posedge clk); #1;
      drive(0, 1'b1, 16'h0041, WR, 16'h0BAD);
      wait_ack(0, c);
      drive(0, 1'b0, 16'h0041, WR, 16'h0BAD);
      @(posedge clk); #1;

      // Reset during the first ACCESS cycle drops the transaction
      drive(0, 1'b1, 16'h0050, WR, 16'h7777);
      @(posedge clk); #1;
      chk("abort_bus_en_up", 32'(bus_en), 1);
      rst = 1'b1;
      drive(0, 1'b0, 16'h0050, WR, 16'h7777);
      #1;
      chk("abort_bus_en", 32'(bus_en), 0);
      chk("abort_bus_oe", 32'(bus_oe), 0);
      chk("abort_m1_rdata", 32'(m1_rdata), 0);
      exp_rd0 = '0;
      exp_rd1 = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Contention: both masters hold req for two transactions each
`ifdef IO_ARB_RR_EN
      exp_push(1'b0, 16'h0100, WR, 16'h1000);
      exp_push(1'b1, 16'h0200, RD, 16'h0000);
      exp_push(1'b0, 16'h0101, WR, 16'h1001);
      exp_push(1'b1, 16'h0201, RD, 16'h0001);
`else
      exp_push(1'b0, 16'h0100, WR, 16'h1000);
      exp_push(1'b0, 16'h0101, WR, 16'h1001);
      exp_push(1'b1, 16'h0200, RD, 16'h0000);
      exp_push(1'b1, 16'h0201, RD, 16'h0001);
`endif
      fork
         run_master(0, 2, 16'h0100, WR, 16'h1000, c0);
         run_master(1, 2, 16'h0200, RD, 16'h0000, c1);
      join
      chk("cont_m0_first", 32'(c0), 32'(AC + 1));
`ifdef IO_ARB_RR_EN
      chk("cont_m1_first", 32'(c1), 32'(2 * AC + 3));
`else
      chk("cont_m1_first", 32'(c1), 32'(3 * AC + 5));
`endif
      repeat (4) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sbq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
